// File: rtl/noc_leaf_injector.sv
// Credit-based injection stage: 2-entry skid buffer feeding one tree leaf port with per-VC credits.
// Optional NOC_INJ_STATS_EN adds stat_sent / stat_stall counters.
module noc_leaf_injector #(
  parameter int unsigned VC_W          = 8,
  parameter int unsigned A_W           = 6,
  parameter int unsigned D_W           = 8,
  parameter int unsigned VC_FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(VC_W)-1:0]    in_vc,
  input  logic [A_W-1:0]             in_dest,
  input  logic [D_W-1:0]             in_data,
  output logic [VC_W-1:0]            vc_target,
  output logic [A_W+D_W-1:0]         packet,
  input  logic [VC_W-1:0]            vc_credit_gnt,
`ifdef NOC_INJ_STATS_EN
  output logic [31:0]                stat_sent,
  output logic [31:0]                stat_stall,
`endif
  output logic                       credit_err
);

  localparam int unsigned VCI_W = $clog2(VC_W);
  localparam int unsigned CR_W  = $clog2(VC_FIFO_DEPTH);
  localparam int unsigned PKT_W = A_W + D_W;
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(VC_FIFO_DEPTH - 1);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;

  buf_state_e        state_q, state_d;
  logic [VCI_W-1:0]  vc0_q, vc1_q;
  logic [PKT_W-1:0]  pk0_q, pk1_q;
  logic [CR_W-1:0]   credit_q [VC_W];
  logic [CR_W-1:0]   credit_d [VC_W];
  logic [VC_W-1:0]   dec_c, ovf_c;
  logic              vc_bad_c, push_c, pop_c, head_valid_c, head_credit_c;

  // Out-of-range VC index only possible when VC_W is not a power of two
  generate
    if ((1 << VCI_W) > VC_W) begin : g_vc_chk
      assign vc_bad_c = (32'(in_vc) >= 32'(VC_W));
    end else begin : g_vc_ok
      assign vc_bad_c = 1'b0;
    end
  endgenerate

  assign head_valid_c  = (state_q != EMPTY);
  assign head_credit_c = (credit_q[vc0_q] != '0);
  assign push_c        = in_valid && in_ready && !vc_bad_c;
  assign pop_c         = head_valid_c && head_credit_c;
  assign dec_c         = pop_c ? (VC_W'(1) << vc0_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push_c) state_d = ONE;
      ONE: begin
        if (push_c && !pop_c)      state_d = TWO;
        else if (!push_c && pop_c) state_d = EMPTY;
      end
      TWO:     if (pop_c) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Slot 0 is always the head; a pop shifts slot 1 forward, a push lands behind the head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc0_q <= '0;
      vc1_q <= '0;
      pk0_q <= '0;
      pk1_q <= '0;
    end else begin
      if (pop_c) begin
        vc0_q <= vc1_q;
        pk0_q <= pk1_q;
      end
      if (push_c) begin
        if (state_q == EMPTY || (state_q == ONE && pop_c)) begin
          vc0_q <= in_vc;
          pk0_q <= {in_dest, in_data};
        end else begin
          vc1_q <= in_vc;
          pk1_q <= {in_dest, in_data};
        end
      end
    end
  end

  // Send decrements, grant increments, both cancel; grant on a full counter saturates and flags
  always_comb begin
    ovf_c = '0;
    for (int v = 0; v < int'(VC_W); v++) begin
      credit_d[v] = credit_q[v];
      if (vc_credit_gnt[v] && !dec_c[v]) begin
        if (credit_q[v] == CR_MAX) ovf_c[v] = 1'b1;
        else                       credit_d[v] = credit_q[v] + CR_W'(1);
      end else if (dec_c[v] && !vc_credit_gnt[v]) begin
        credit_d[v] = credit_q[v] - CR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < int'(VC_W); v++) credit_q[v] <= CR_MAX;
    end else begin
      for (int v = 0; v < int'(VC_W); v++) credit_q[v] <= credit_d[v];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc_target  <= '0;
      packet     <= '0;
      in_ready   <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      vc_target  <= dec_c;
      if (pop_c) packet <= pk0_q;
      in_ready   <= (state_d != TWO);
      credit_err <= credit_err || (|ovf_c) || (in_valid && in_ready && vc_bad_c);
    end
  end

`ifdef NOC_INJ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sent  <= '0;
      stat_stall <= '0;
    end else begin
      if (pop_c)                          stat_sent  <= stat_sent + 32'd1;
      if (head_valid_c && !head_credit_c) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
